// File: rtl/video_pkg.sv
// Shared video definitions: default raster size, address-width helper,
// write FSM encoding and {R,G,B} pixel pack/unpack macros.
`ifndef VIDEO_PKG_MACROS
`define VIDEO_PKG_MACROS
`define VIDEO_PIX_PACK(r, g, b) {r, g, b}
`define VIDEO_PIX_R(p, w) p[3*(w)-1:2*(w)]
`define VIDEO_PIX_G(p, w) p[2*(w)-1:(w)]
`define VIDEO_PIX_B(p, w) p[(w)-1:0]
`endif

package video_pkg;

    localparam int unsigned X_PIXELS_DEF   = 800;
    localparam int unsigned Y_PIXELS_DEF   = 600;
    localparam int unsigned COLOR_BITS_DEF = 8;
    localparam int unsigned COORD_W_DEF    = 10;

    // Smallest width able to address v words; never narrower than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    typedef enum logic {
        ST_FILL      = 1'b0,
        ST_WAIT_SWAP = 1'b1
    } wr_state_e;

endpackage

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port RAM, one write port and one registered
// read port on a common clock. The read register holds while re_i is low.
module fb_bank #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned DEPTH  = 480000
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_double_buffer.sv
// Double-buffered frame store: renderer fills the back bank in raster order,
// scanout reads the front bank; banks swap only on frame_start with a full back frame.
module frame_double_buffer
    import video_pkg::*;
#(
    parameter int unsigned X_PIXELS   = X_PIXELS_DEF,
    parameter int unsigned Y_PIXELS   = Y_PIXELS_DEF,
    parameter int unsigned COLOR_BITS = COLOR_BITS_DEF,
    parameter int unsigned COORD_W    = COORD_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  newFrame,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [COLOR_BITS-1:0] iR,
    input  logic [COLOR_BITS-1:0] iG,
    input  logic [COLOR_BITS-1:0] iB,
    output logic [COORD_W-1:0]    buffX,
    output logic [COORD_W-1:0]    buffY,
    input  logic                  frame_start,
    input  logic                  rd_en,
    input  logic [COORD_W-1:0]    scanX,
    input  logic [COORD_W-1:0]    scanY,
    output logic [COLOR_BITS-1:0] oR,
    output logic [COLOR_BITS-1:0] oG,
    output logic [COLOR_BITS-1:0] oB,
    output logic                  rd_valid,
    output logic                  front_bank,
    output logic                  swapped,
    output logic                  frame_dropped
);

    localparam int unsigned PIX_W  = 3 * COLOR_BITS;
    localparam int unsigned DEPTH  = X_PIXELS * Y_PIXELS;
    localparam int unsigned ADDR_W = clog2(DEPTH);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_PIXELS - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_PIXELS - 1);
    localparam logic [COORD_W-1:0] X_LIM  = COORD_W'(X_PIXELS);
    localparam logic [COORD_W-1:0] Y_LIM  = COORD_W'(Y_PIXELS);

    wr_state_e          state_q, state_d;
    logic [COORD_W-1:0] buff_x_q, buff_x_d;
    logic [COORD_W-1:0] buff_y_q, buff_y_d;
    logic               front_q, front_d;
    logic               wr_ready_q;
    logic               swapped_q, swapped_d;
    logic               dropped_q, dropped_d;
    logic               rd_valid_q;
    logic               rd_bank_q;
    logic               rd_oor_q;
    logic               wr_en_c;

    logic [ADDR_W-1:0]  wr_addr_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic [PIX_W-1:0]   wr_pix_c;
    logic               in_range_c;
    logic               rd_hit_c;
    logic [PIX_W-1:0]   rd_data0, rd_data1, rd_pix_c;

    // Write FSM: coordinate stepping, frame completion, swap and drop decisions.
    always_comb begin
        state_d   = state_q;
        buff_x_d  = buff_x_q;
        buff_y_d  = buff_y_q;
        front_d   = front_q;
        swapped_d = 1'b0;
        dropped_d = 1'b0;
        wr_en_c   = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (frame_start) begin
                    dropped_d = 1'b1;
                end
                if (newFrame) begin
                    buff_x_d = '0;
                    buff_y_d = '0;
                end else if (wr_valid) begin
                    wr_en_c = !reset;
                    if (buff_x_q == X_LAST) begin
                        buff_x_d = '0;
                        if (buff_y_q == Y_LAST) begin
                            buff_y_d = '0;
                            state_d  = ST_WAIT_SWAP;
                        end else begin
                            buff_y_d = buff_y_q + COORD_W'(1);
                        end
                    end else begin
                        buff_x_d = buff_x_q + COORD_W'(1);
                    end
                end
            end
            ST_WAIT_SWAP: begin
                if (frame_start) begin
                    front_d   = ~front_q;
                    swapped_d = 1'b1;
                    state_d   = ST_FILL;
                end
                if (newFrame) begin
                    buff_x_d = '0;
                    buff_y_d = '0;
                    state_d  = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_FILL;
            buff_x_q   <= '0;
            buff_y_q   <= '0;
            front_q    <= 1'b0;
            wr_ready_q <= 1'b1;
            swapped_q  <= 1'b0;
            dropped_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_oor_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            buff_x_q   <= buff_x_d;
            buff_y_q   <= buff_y_d;
            front_q    <= front_d;
            wr_ready_q <= (state_d == ST_FILL);
            swapped_q  <= swapped_d;
            dropped_q  <= dropped_d;
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_bank_q <= front_q;
                rd_oor_q  <= ~in_range_c;
            end
        end
    end

    assign wr_addr_c  = ADDR_W'(buff_y_q) * ADDR_W'(X_PIXELS) + ADDR_W'(buff_x_q);
    assign rd_addr_c  = ADDR_W'(scanY) * ADDR_W'(X_PIXELS) + ADDR_W'(scanX);
    assign wr_pix_c   = `VIDEO_PIX_PACK(iR, iG, iB);
    assign in_range_c = (scanX < X_LIM) && (scanY < Y_LIM);
    assign rd_hit_c   = rd_en && in_range_c;

    // Back bank (~front) takes writes; front bank serves reads.
    fb_bank #(.DATA_W(PIX_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank0 (
        .clock   (clock),
        .we_i    (wr_en_c && front_q),
        .waddr_i (wr_addr_c),
        .wdata_i (wr_pix_c),
        .re_i    (rd_hit_c && !front_q),
        .raddr_i (rd_addr_c),
        .rdata_o (rd_data0)
    );

    fb_bank #(.DATA_W(PIX_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank1 (
        .clock   (clock),
        .we_i    (wr_en_c && !front_q),
        .waddr_i (wr_addr_c),
        .wdata_i (wr_pix_c),
        .re_i    (rd_hit_c && front_q),
        .raddr_i (rd_addr_c),
        .rdata_o (rd_data1)
    );

    // Out-of-range reads return zero; bank registers hold between reads.
    assign rd_pix_c = rd_oor_q ? '0 : (rd_bank_q ? rd_data1 : rd_data0);

    assign oR            = `VIDEO_PIX_R(rd_pix_c, COLOR_BITS);
    assign oG            = `VIDEO_PIX_G(rd_pix_c, COLOR_BITS);
    assign oB            = `VIDEO_PIX_B(rd_pix_c, COLOR_BITS);
    assign wr_ready      = wr_ready_q;
    assign buffX         = buff_x_q;
    assign buffY         = buff_y_q;
    assign rd_valid      = rd_valid_q;
    assign front_bank    = front_q;
    assign swapped       = swapped_q;
    assign frame_dropped = dropped_q;

endmodule

// File: tb/tb_frame_double_buffer.sv
// Directed bench for frame_double_buffer on an 8x4 raster.
module tb_frame_double_buffer;

    localparam int unsigned XP = 8;
    localparam int unsigned YP = 4;
    localparam int unsigned CB = 8;
    localparam int unsigned CW = 10;

    logic          clock = 1'b0;
    logic          reset, newFrame, wr_valid, frame_start, rd_en;
    logic          wr_ready, rd_valid, front_bank, swapped, frame_dropped;
    logic [CB-1:0] iR, iG, iB, oR, oG, oB;
    logic [CW-1:0] buffX, buffY, scanX, scanY;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    frame_double_buffer #(.X_PIXELS(XP), .Y_PIXELS(YP), .COLOR_BITS(CB), .COORD_W(CW)) dut (
        .clock(clock), .reset(reset), .newFrame(newFrame), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .iR(iR), .iG(iG), .iB(iB), .buffX(buffX), .buffY(buffY),
        .frame_start(frame_start), .rd_en(rd_en), .scanX(scanX), .scanY(scanY),
        .oR(oR), .oG(oG), .oB(oB), .rd_valid(rd_valid), .front_bank(front_bank),
        .swapped(swapped), .frame_dropped(frame_dropped)
    );

    typedef struct {
        logic        en;
        int          sx;
        int          sy;
        logic        exp_valid;
        logic [23:0] exp_pix;
    } rd_vec_t;

    rd_vec_t rtab[10];

    // Frame 0 stores its address; later frames use distinct per-channel values.
    function automatic logic [23:0] pix_of(input int kind, input int a);
        if (kind == 0) return 24'(a);
        return {8'(a), 8'(kind), 8'(255 - a)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input int bx, input int by, input int rdy,
                           input int fr, input int sw, input int dr);
        chk({tag, "_buffX"}, 32'(buffX), 32'(bx));
        chk({tag, "_buffY"}, 32'(buffY), 32'(by));
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'(rdy));
        chk({tag, "_front"}, 32'(front_bank), 32'(fr));
        chk({tag, "_swapped"}, 32'(swapped), 32'(sw));
        chk({tag, "_dropped"}, 32'(frame_dropped), 32'(dr));
    endtask

    task automatic push(input int kind, input int a);
        wr_valid = 1'b1;
        {iR, iG, iB} = pix_of(kind, a);
        step();
        wr_valid = 1'b0;
        chk("fill_buffX", 32'(buffX), 32'((a + 1) % 8));
        chk("fill_buffY", 32'(buffY), 32'(((a + 1) % 32) / 8));
        chk("fill_wr_ready", 32'(wr_ready), (a == 31) ? 32'd0 : 32'd1);
    endtask

    task automatic fill(input int kind, input int from, input int to);
        for (int a = from; a <= to; a++) push(kind, a);
    endtask

    task automatic rd(input string tag, input int sx, input int sy, input logic [23:0] exp);
        rd_en = 1'b1;
        scanX = CW'(sx);
        scanY = CW'(sy);
        step();
        rd_en = 1'b0;
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
        chk({tag, "_pix"}, 32'({oR, oG, oB}), 32'(exp));
    endtask

    initial begin
        rtab[0] = '{1'b1, 5, 2, 1'b1, 24'd21};
        rtab[1] = '{1'b1, 0, 0, 1'b1, 24'd0};
        rtab[2] = '{1'b1, 7, 3, 1'b1, 24'd31};
        rtab[3] = '{1'b0, 7, 3, 1'b0, 24'd31};
        rtab[4] = '{1'b1, 8, 0, 1'b1, 24'd0};
        rtab[5] = '{1'b1, 3, 1, 1'b1, 24'd11};
        rtab[6] = '{1'b0, 0, 0, 1'b0, 24'd11};
        rtab[7] = '{1'b1, 0, 4, 1'b1, 24'd0};
        rtab[8] = '{1'b1, 1023, 1023, 1'b1, 24'd0};
        rtab[9] = '{1'b1, 6, 0, 1'b1, 24'd6};

        reset = 1'b1; newFrame = 1'b0; wr_valid = 1'b0; frame_start = 1'b0; rd_en = 1'b0;
        iR = '0; iG = '0; iB = '0; scanX = '0; scanY = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_ctl("reset", 0, 0, 1, 0, 0, 0);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_pix", 32'({oR, oG, oB}), 32'd0);

        // Frame 0 into bank 1; a pixel offered during WAIT_SWAP must be ignored.
        fill(0, 0, 31);
        wr_valid = 1'b1;
        {iR, iG, iB} = 24'hABCDEF;
        step();
        wr_valid = 1'b0;
        chk_ctl("wait", 0, 0, 0, 0, 0, 0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk_ctl("swap1", 0, 0, 1, 1, 1, 0);
        step();
        chk("swap1_pulse_end", 32'(swapped), 32'd0);

        for (int i = 0; i < 10; i++) begin
            rd_en = rtab[i].en;
            scanX = CW'(rtab[i].sx);
            scanY = CW'(rtab[i].sy);
            step();
            chk("tab_rd_valid", 32'(rd_valid), 32'(rtab[i].exp_valid));
            chk("tab_pix", 32'({oR, oG, oB}), 32'(rtab[i].exp_pix));
        end
        rd_en = 1'b0;

        // Frame 1 into bank 0 with a dropped frame_start mid-fill.
        fill(1, 0, 9);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk_ctl("drop", 2, 1, 1, 1, 0, 1);
        fill(1, 10, 30);
        chk("drop_pulse_end", 32'(frame_dropped), 32'd0);
        wr_valid = 1'b1;
        frame_start = 1'b1;
        {iR, iG, iB} = pix_of(1, 31);
        step();
        wr_valid = 1'b0;
        frame_start = 1'b0;
        chk_ctl("last_coinc", 0, 0, 0, 1, 0, 1);
        step();
        chk_ctl("last_after", 0, 0, 0, 1, 0, 0);

        // Read in the swap cycle sees the old bank; the next read sees the new one.
        frame_start = 1'b1;
        rd_en = 1'b1;
        scanX = CW'(5);
        scanY = CW'(2);
        step();
        frame_start = 1'b0;
        chk_ctl("swap2", 0, 0, 1, 0, 1, 0);
        chk("swap2_old_pix", 32'({oR, oG, oB}), 32'(pix_of(0, 21)));
        rd("swap2_new", 5, 2, pix_of(1, 21));

        // Frame 2 into bank 1; newFrame with frame_start in WAIT_SWAP still swaps.
        fill(2, 0, 31);
        newFrame = 1'b1;
        frame_start = 1'b1;
        wr_valid = 1'b1;
        {iR, iG, iB} = 24'h123456;
        step();
        newFrame = 1'b0;
        frame_start = 1'b0;
        wr_valid = 1'b0;
        chk_ctl("nf_swap", 0, 0, 1, 1, 1, 0);
        rd("nf_swap_rd", 3, 3, pix_of(2, 27));

        // Abort after 13 pixels; the concurrent handshake must not write address 13.
        fill(3, 0, 12);
        newFrame = 1'b1;
        wr_valid = 1'b1;
        {iR, iG, iB} = 24'h5A5A5A;
        step();
        newFrame = 1'b0;
        wr_valid = 1'b0;
        chk_ctl("abort", 0, 0, 1, 1, 0, 0);
        fill(4, 0, 4);

        // Reset mid-fill exposes bank 0 without clearing it.
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_ctl("rst_fill", 0, 0, 1, 0, 0, 0);
        chk("rst_fill_rd_valid", 32'(rd_valid), 32'd0);
        rd("abort_new", 2, 0, pix_of(4, 2));
        rd("abort_part", 7, 0, pix_of(3, 7));
        rd("abort_skip", 5, 1, pix_of(1, 13));
        rd("abort_old", 4, 2, pix_of(1, 20));

        // Reset while WAIT_SWAP with front_bank=1.
        fill(5, 0, 31);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk_ctl("swap3", 0, 0, 1, 1, 1, 0);
        fill(6, 0, 31);
        chk_ctl("wait3", 0, 0, 0, 1, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_ctl("rst_wait", 0, 0, 1, 0, 0, 0);
        rd("rst_wait_rd", 1, 3, pix_of(6, 25));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_double_buffer.md
# frame_double_buffer

Parametrised double-buffered frame store between the renderer and the VGA scanout. The renderer fills the back bank with a raster-ordered pixel stream using a valid/ready handshake and block-generated coordinates. Scanout reads the front bank by coordinate with fixed 1-cycle latency. Banks swap only at a scanout frame boundary, and only once the back frame is complete, so a torn frame is never displayed.

## Interface
Parameters:
- X_PIXELS, 800: active pixels per line.
- Y_PIXELS, 600: active lines per frame.
- COLOR_BITS, 8: bits per colour channel; stored pixel width is 3*COLOR_BITS.
- COORD_W, 10: width of every x/y coordinate port.

Ports:
- clock  in  1  single clock for both sides (already decided)
- reset  in  1  synchronous, active-high (already decided)
- newFrame  in  1  renderer pulse: abort the current fill and restart at (0,0)
- wr_valid  in  1  renderer pixel valid
- wr_ready  out  1  block can accept a pixel
- iR, iG, iB  in  COLOR_BITS each  pixel colour, written at (buffX, buffY)
- buffX, buffY  out  COORD_W each  coordinate of the next pixel the block expects
- frame_start  in  1  scanout pulse, one cycle at vertical blank
- rd_en  in  1  scanout read request
- scanX, scanY  in  COORD_W each  scanout read coordinate
- oR, oG, oB  out  COLOR_BITS each  pixel read from the front bank
- rd_valid  out  1  oR/oG/oB valid
- front_bank  out  1  index of the bank currently displayed
- swapped  out  1  one-cycle pulse on each bank swap
- frame_dropped  out  1  one-cycle pulse when frame_start arrives and no complete back frame is ready

## Operation
- Bank storage: two banks, each X_PIXELS*Y_PIXELS words of 3*COLOR_BITS bits.
- Address: buffY*X_PIXELS + buffX, ADDR_W = clog2(X_PIXELS*Y_PIXELS) bits. The multiplier is X_PIXELS, never Y_PIXELS.
- Word packing is {R,G,B}, concatenated. Channels are never summed.
- Write FSM has two states, FILL and WAIT_SWAP.
- FILL:
  - wr_ready=1.
  - On wr_valid&wr_ready, write the pixel to bank ~front_bank at (buffX, buffY).
  - Then buffX++. At X_PIXELS-1, buffX wraps to 0 and buffY++.
  - On the write of (X_PIXELS-1, Y_PIXELS-1), go to WAIT_SWAP, with buffX/buffY returning to 0.
- WAIT_SWAP: wr_ready=0 and no writes. On frame_start: toggle front_bank, pulse swapped, go to FILL.
- frame_start in FILL: no swap, pulse frame_dropped; the fill continues.
- newFrame, in either state: buffX=buffY=0, state FILL, no swap. Any partial back frame is discarded by being overwritten.
- Read path:
  - On rd_en, read bank front_bank at (scanX, scanY).
  - If scanX≥X_PIXELS or scanY≥Y_PIXELS, return 0 and do not access RAM.
  - Without rd_en, rd_valid=0 and oR/oG/oB hold their last value.
- RAM contents are not cleared by reset.

## Timing
- Reset values: buffX=buffY=0, state FILL, wr_ready=1 from the first cycle after reset, front_bank=0, swapped=frame_dropped=0, rd_valid=0, oR=oG=oB=0.
- Write: one pixel per cycle sustained. buffX/buffY update the cycle after the handshake.
- Read latency: exactly 1 cycle, rd_en@N gives rd_valid and data@N+1. Reads are fully pipelined, one per cycle.
- front_bank is sampled with the read address. A read issued in the swap cycle uses the pre-swap bank; a read in the next cycle uses the new bank.
- Simultaneous events:
  - Last-pixel handshake with frame_start in the same cycle: the pixel is written, frame_dropped pulses, state goes to WAIT_SWAP, and the swap waits for the next frame_start.
  - newFrame with frame_start in WAIT_SWAP: the swap is taken and the fill restarts at (0,0). newFrame beats a handshake in the same cycle, and that pixel is not written.
- Reset mid-fill: state returns to FILL at (0,0) and front_bank=0 on the next cycle.

## Structure
- Package video_pkg: X_PIXELS/Y_PIXELS defaults, the clog2 address-width function, the FSM state encodings, and the pixel pack/unpack macros for {R,G,B}.
- Sub-module fb_bank: simple dual-port RAM with one write port, one registered read port, and the same clock, inferred for M10K. It is instantiated twice, with write and read enables steered by front_bank.
- Top level: the write FSM, coordinate counters, address multiply, bank steering and output mux.

## Test plan
Parameters X_PIXELS=8, Y_PIXELS=4.
- Reset: after reset, wr_ready=1, buffX=buffY=0, front_bank=0, rd_valid=0.
- Full fill with swap: stream 32 pixels with value = address. State goes to WAIT_SWAP, wr_ready=0, buffX/buffY=0. On frame_start, front_bank=1 and swapped pulses once. Reading (5,2) gives {R,G,B}=21 one cycle later.
- Frame drop: frame_start after 10 pixels gives frame_dropped=1, front_bank unchanged, buffX=2, buffY=1. Filling continues correctly.
- Out-of-range read: rd_en with scanX=8, scanY=0 gives rd_valid=1 and oR=oG=oB=0 next cycle.
- Coincident events:
  - Last pixel and frame_start in the same cycle: frame_dropped=1, no swap; the swap happens on the following frame_start.
  - Read issued in the swap cycle returns old-bank data.
- Abort: newFrame after 13 pixels gives buffX=buffY=0. A handshake in that same cycle leaves the bank unwritten.
- Reset mid-WAIT_SWAP: state FILL, front_bank=0, wr_ready=1 next cycle.
